// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter_if : I-fetch, load/store and memory port bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if;
  // Instruction-fetch requester
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        i_rsp_err;

  // Load/store requester
  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [3:0]  d_req_mask;
  logic [31:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;

  // Memory port 0
  logic        mem_wr_en;
  logic [3:0]  mem_wr_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    input  d_req_valid, d_req_addr, d_req_we, d_req_mask, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_wr_en, mem_wr_mask, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester / memory-model view
  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    output d_req_valid, d_req_addr, d_req_we, d_req_mask, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_wr_en, mem_wr_mask, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter : shares memory port 0 between I-fetch and load/store.
// Optional MEM_ARB_RR_EN selects round-robin instead of fixed priority.
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MEM_SIZE = 128,
  parameter int unsigned MAX_WAIT = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Misaligned or any byte of the word past the end of memory
  function automatic logic addr_bad(input logic [31:0] a);
    addr_bad = (a[1:0] != 2'b00) ||
               (({1'b0, a} + 33'd3) >= 33'(MEM_SIZE));
  endfunction

  logic  gnt_i;
  logic  gnt_d;
  logic  i_bad;
  logic  d_bad;

  assign i_bad = addr_bad(bus.i_req_addr);
  assign d_bad = addr_bad(bus.d_req_addr);

`ifdef MEM_ARB_RR_EN
  logic prio_d_q;
  logic prio_d_d;

  always_comb begin
    gnt_i    = 1'b0;
    gnt_d    = 1'b0;
    prio_d_d = prio_d_q;
    if (!rst) begin
      if (bus.i_req_valid && bus.d_req_valid) begin
        gnt_d = prio_d_q;
        gnt_i = !prio_d_q;
      end else begin
        gnt_i = bus.i_req_valid;
        gnt_d = bus.d_req_valid;
      end
    end
    // Favour whichever port was not served by this handshake
    if (gnt_d) begin
      prio_d_d = 1'b0;
    end else if (gnt_i) begin
      prio_d_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_d_q <= 1'b1;
    end else begin
      prio_d_q <= prio_d_d;
    end
  end
`else
  localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_q;
  logic [CNT_W-1:0] wait_d;
  logic             starve;

  assign starve = (wait_q == CNT_W'(MAX_WAIT));

  always_comb begin
    gnt_i  = 1'b0;
    gnt_d  = 1'b0;
    wait_d = wait_q;
    if (!rst) begin
      if (bus.i_req_valid && bus.d_req_valid) begin
        gnt_i = starve;
        gnt_d = !starve;
      end else begin
        gnt_i = bus.i_req_valid;
        gnt_d = bus.d_req_valid;
      end
    end
    // Counter cannot pass MAX_WAIT: at that value I wins any contention
    if (!bus.i_req_valid || gnt_i) begin
      wait_d = '0;
    end else if (!starve) begin
      wait_d = wait_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  assign bus.i_req_ready = gnt_i;
  assign bus.d_req_ready = gnt_d;

  always_comb begin
    bus.mem_addr    = 32'd0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_mask = 4'd0;
    bus.mem_wdata   = 32'd0;
    if (gnt_d) begin
      bus.mem_addr  = bus.d_req_addr;
      bus.mem_wdata = bus.d_req_wdata;
      if (bus.d_req_we && !d_bad) begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_mask = bus.d_req_mask;
      end
    end else if (gnt_i) begin
      bus.mem_addr = bus.i_req_addr;
    end
  end

  // Response tag: one entry covers the single cycle of memory latency
  logic  tag_vld_q;
  logic  tag_vld_d;
  port_e tag_port_q;
  port_e tag_port_d;
  logic  tag_we_q;
  logic  tag_we_d;
  logic  tag_err_q;
  logic  tag_err_d;

  always_comb begin
    tag_vld_d  = gnt_i || gnt_d;
    tag_port_d = gnt_d ? PORT_D : PORT_I;
    tag_we_d   = gnt_d && bus.d_req_we;
    tag_err_d  = 1'b0;
    if (gnt_d) begin
      tag_err_d = d_bad;
    end else if (gnt_i) begin
      tag_err_d = i_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q  <= 1'b0;
      tag_port_q <= PORT_D;
      tag_we_q   <= 1'b0;
      tag_err_q  <= 1'b0;
    end else begin
      tag_vld_q  <= tag_vld_d;
      tag_port_q <= tag_port_d;
      tag_we_q   <= tag_we_d;
      tag_err_q  <= tag_err_d;
    end
  end

  logic        rsp_live;
  logic        rsp_i;
  logic        rsp_d;
  logic [31:0] rsp_data;

  // rst is synchronous, so gate here to drop a response whose cycle is reset
  assign rsp_live = tag_vld_q && !rst;
  assign rsp_i    = rsp_live && (tag_port_q == PORT_I);
  assign rsp_d    = rsp_live && (tag_port_q == PORT_D);
  assign rsp_data = (tag_we_q || tag_err_q) ? 32'd0 : bus.mem_rdata;

  assign bus.i_rsp_valid = rsp_i;
  assign bus.i_rsp_err   = rsp_i && tag_err_q;
  assign bus.i_rsp_data  = rsp_i ? rsp_data : 32'd0;

  assign bus.d_rsp_valid = rsp_d;
  assign bus.d_rsp_err   = rsp_d && tag_err_q;
  assign bus.d_rsp_data  = rsp_d ? rsp_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter : directed bench with a byte-addressed memory model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MEM_SIZE(128),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Big-endian byte memory: mask bit3 / data[31:24] map to the byte at addr
  logic [7:0] mem [0:127];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (a + 32'(k) < 32'd128) w[31-8*k -: 8] = mem[a + 32'(k)];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.mem_wr_mask[3-k] && (bus.mem_addr + 32'(k) < 32'd128))
          mem[bus.mem_addr + 32'(k)] <= bus.mem_wdata[31-8*k -: 8];
      end
    end
    bus.mem_rdata <= rd_word(bus.mem_addr);
  end

  task automatic put_word(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[a + k] = w[31-8*k -: 8];
  endtask

  task automatic idle();
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = 32'd0;
    bus.d_req_valid = 1'b0;
    bus.d_req_addr  = 32'd0;
    bus.d_req_we    = 1'b0;
    bus.d_req_mask  = 4'd0;
    bus.d_req_wdata = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_req(input logic [31:0] a, input logic we, input logic [3:0] m, input logic [31:0] wd);
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = a;
    bus.d_req_we    = we;
    bus.d_req_mask  = m;
    bus.d_req_wdata = wd;
  endtask

  localparam logic [31:0] W64  = 32'hFE010113;
  localparam logic [31:0] W68  = 32'h00A00093;
  localparam logic [31:0] W124 = 32'h11225A44;

  logic exp_i [0:9];

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_i = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    put_word(64, W64);
    put_word(68, W68);
    put_word(124, W124);
    bus.mem_rdata = 32'd0;
    idle();

    // Reset with both requesters pushing
    rst = 1'b1;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'd64;
    d_req(32'd100, 1'b1, 4'hF, 32'h12345678);
    tick();
    tick();
    check("rst_i_ready", bus.i_req_ready, 0);
    check("rst_d_ready", bus.d_req_ready, 0);
    check("rst_wr_en", bus.mem_wr_en, 0);
    check("rst_wr_mask", bus.mem_wr_mask, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_i_rsp_valid", bus.i_rsp_valid, 0);
    check("rst_d_rsp_valid", bus.d_rsp_valid, 0);
    check("rst_d_rsp_data", bus.d_rsp_data, 0);
    idle();
    rst = 1'b0;

    // I fetch
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'd64;
    #1;
    check("if_i_ready", bus.i_req_ready, 1);
    check("if_d_ready", bus.d_req_ready, 0);
    check("if_mem_addr", bus.mem_addr, 32'd64);
    tick();
    idle();
    check("if_rsp_valid", bus.i_rsp_valid, 1);
    check("if_rsp_data", bus.i_rsp_data, W64);
    check("if_rsp_err", bus.i_rsp_err, 0);
    check("if_d_rsp_valid", bus.d_rsp_valid, 0);

    // D masked write, then read-back the next cycle
    d_req(32'd100, 1'b1, 4'b0110, 32'hAABBCCDD);
    #1;
    check("wr_d_ready", bus.d_req_ready, 1);
    check("wr_en", bus.mem_wr_en, 1);
    check("wr_mask", bus.mem_wr_mask, 4'b0110);
    check("wr_wdata", bus.mem_wdata, 32'hAABBCCDD);
    tick();
    d_req(32'd100, 1'b0, 4'h0, 32'd0);
    check("wr_rsp_valid", bus.d_rsp_valid, 1);
    check("wr_rsp_data", bus.d_rsp_data, 0);
    check("wr_rsp_err", bus.d_rsp_err, 0);
    check("wr_i_rsp_valid", bus.i_rsp_valid, 0);
    #1;
    check("rd_wr_en", bus.mem_wr_en, 0);
    tick();
    idle();
    check("rd_rsp_valid", bus.d_rsp_valid, 1);
    check("rd_rsp_data", bus.d_rsp_data, 32'h00BBCC00);

    // Out-of-range write: accepted, no memory write, error reported
    d_req(32'd126, 1'b1, 4'hF, 32'hFFFFFFFF);
    #1;
    check("ewr_d_ready", bus.d_req_ready, 1);
    check("ewr_wr_en", bus.mem_wr_en, 0);
    check("ewr_wr_mask", bus.mem_wr_mask, 0);
    tick();
    idle();
    check("ewr_rsp_valid", bus.d_rsp_valid, 1);
    check("ewr_rsp_err", bus.d_rsp_err, 1);
    check("ewr_rsp_data", bus.d_rsp_data, 0);
    check("ewr_mem126", {24'd0, mem[126]}, 32'h5A);

    // Misaligned fetch
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'd65;
    #1;
    check("emis_i_ready", bus.i_req_ready, 1);
    tick();
    idle();
    check("emis_rsp_valid", bus.i_rsp_valid, 1);
    check("emis_rsp_err", bus.i_rsp_err, 1);
    check("emis_rsp_data", bus.i_rsp_data, 0);

    // Last legal word, then first aligned illegal word
    d_req(32'd124, 1'b0, 4'h0, 32'd0);
    tick();
    d_req(32'd128, 1'b0, 4'h0, 32'd0);
    check("b124_err", bus.d_rsp_err, 0);
    check("b124_data", bus.d_rsp_data, W124);
    tick();
    idle();
    check("b128_valid", bus.d_rsp_valid, 1);
    check("b128_err", bus.d_rsp_err, 1);
    check("b128_data", bus.d_rsp_data, 0);

    // Contention from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'd64;
    d_req(32'd68, 1'b0, 4'h0, 32'd0);
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("cont%0d_i_ready", c), bus.i_req_ready, exp_i[c]);
      check($sformatf("cont%0d_d_ready", c), bus.d_req_ready, !exp_i[c]);
      tick();
      check($sformatf("cont%0d_i_rsp", c), bus.i_rsp_valid, exp_i[c]);
      check($sformatf("cont%0d_d_rsp", c), bus.d_rsp_valid, !exp_i[c]);
      check($sformatf("cont%0d_data", c),
            exp_i[c] ? bus.i_rsp_data : bus.d_rsp_data, exp_i[c] ? W64 : W68);
    end
    idle();

    // Reset lands on the response cycle of an accepted read
    d_req(32'd100, 1'b0, 4'h0, 32'd0);
    #1;
    check("mid_d_ready", bus.d_req_ready, 1);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rsp_suppressed", bus.d_rsp_valid, 0);
    check("mid_rst_d_ready", bus.d_req_ready, 0);
    check("mid_rst_i_ready", bus.i_req_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_no_late_rsp", bus.d_rsp_valid, 0);
    check("mid_resume_ready", bus.d_req_ready, 1);
    tick();
    idle();
    check("mid_resume_valid", bus.d_rsp_valid, 1);
    check("mid_resume_data", bus.d_rsp_data, 32'h00BBCC00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single read/write port (port 0) of the byte-addressed simulation memory between two requesters: the instruction-fetch port (I, read-only) and the load/store port (D, read/write with byte mask).
- Sits between the core's fetch/LSU interfaces and the memory.
- Handles arbitration, bounds/alignment checking, and return of the 1-cycle-latency read data to the correct requester.
- Sustains one accepted request per cycle.

Parameters:
- MEM_SIZE, 128, memory size in bytes; legal word addresses satisfy addr+3 < MEM_SIZE.
- MAX_WAIT, 4, fixed-priority mode only: consecutive cycles I may be denied while valid before it is forced to win.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req_valid  in  1  I request valid
- i_req_ready  out  1  I request accepted this cycle
- i_req_addr  in  32  I byte address
- i_rsp_valid  out  1  I response valid (one cycle pulse)
- i_rsp_data  out  32  I read data
- i_rsp_err  out  1  I access error
- d_req_valid  in  1  D request valid
- d_req_ready  out  1  D request accepted this cycle
- d_req_addr  in  32  D byte address
- d_req_we  in  1  D write
- d_req_mask  in  4  D byte enables; bit3 = byte at addr (bits 31:24)
- d_req_wdata  in  32  D write data
- d_rsp_valid  out  1  D response valid
- d_rsp_data  out  32  D read data (0 for writes)
- d_rsp_err  out  1  D access error
- mem_wr_en  out  1  memory write enable
- mem_wr_mask  out  4  memory byte mask
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, registered, valid the cycle after mem_addr is presented

Behaviour:
- **Reset.** rst is synchronous, active-high, clock clk.
  - Registered outputs during and after reset: i_rsp_valid=0, d_rsp_valid=0, *_rsp_err=0, *_rsp_data=0; starvation counter=0; RR pointer favours D.
  - While rst=1, combinational outputs are forced: i_req_ready=0, d_req_ready=0, mem_wr_en=0, mem_wr_mask=0, mem_addr=0, mem_wdata=0.
- **Grant.** Combinational each cycle from the valids plus the arbitration state.
  - At most one of i_req_ready/d_req_ready is high.
  - Ready is high only if the matching valid is high.
  - A handshake is valid&ready in the same cycle.
- **Memory drive.**
  - mem_addr = granted address, else 0.
  - mem_wr_en = D granted & d_req_we & no error.
  - mem_wr_mask = d_req_mask under the same condition, else 0.
  - mem_wdata = d_req_wdata when D is granted, else 0.
- **Response pipeline.** A 1-deep tag register holds {port, is_write, err}, loaded on accept.
  - In cycle N+1 after accept at N, exactly one rsp_valid pulses for the owning port.
  - rsp_data = mem_rdata for an error-free read; 0 for writes and errors.
  - Responses cannot be back-pressured.
  - Back-to-back accepts yield back-to-back responses.
- **Errors.**
  - Condition: addr[1:0]!=0, or addr+3 >= MEM_SIZE (computed 33-bit, no wrap).
  - The request is still accepted; no memory write; rsp_err=1 at N+1.
- **Fixed-priority mode.**
  - D wins ties.
  - The counter increments each cycle I is valid but not granted, and clears when I is granted or I is not valid.
  - When counter == MAX_WAIT, I wins the next contention, then the counter clears.
- **Reset mid-operation.** rst asserted in the response cycle suppresses that response; the tag is cleared.
- **Simultaneous events.** An I/D request to the same address as a D write accepted the previous cycle sees the written data.

Optional Feature:
- MEM_ARB_RR_EN
- **Defined:** round-robin arbitration replaces fixed priority and the starvation counter.
  - When both are valid, grant goes to the port not granted last.
  - A lone requester is always granted.
  - The pointer updates only on handshake.
  - The first tie after reset goes to D.
- **Undefined:** fixed priority with the MAX_WAIT starvation guard as above.

Test Plan:
- **I fetch.** After reset (memory preloaded), I reads addr 64 -> i_rsp_valid one cycle later, i_rsp_data=0xFE010113, err=0, d_rsp_valid=0.
- **D write then read.** D writes addr 100, mask 4'b0110, wdata 0xAABBCCDD over prior 0x00000000 -> write response data 0, err 0; the next-cycle D read of 100 returns 0x00BBCC00.
- **Contention, fixed mode.** I and D continuously valid (I addr 64, D addr 68) -> grants D,D,D,D,I,D,D,D,D,I...; the response port matches each grant.
- **Contention, MEM_ARB_RR_EN.** Both continuously valid -> grants D,I,D,I...
- **Errors.**
  - D write to addr 126, mask 4'hF -> d_rsp_err=1, mem_wr_en never high, memory unchanged.
  - I read addr 65 -> i_rsp_err=1, data 0.
- **Reset mid-operation.** D read accepted, then rst asserted next cycle -> no d_rsp_valid; both readys 0 while rst=1; normal operation resumes the cycle after rst falls.
